// File: rtl/vit_cmd_sequencer.sv
// Host command queue and bus sequencer for the Viterbi chip-select snipet.
// Optional WAIT_RDY timeout is enabled by defining VIT_SEQ_TIMEOUT_EN.
module vit_cmd_sequencer #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int ACCESS_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_vit,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              vit1_code,
    input  logic              vit2_code,
    input  logic [DATA_W-1:0] vit_rd_data,
    output logic              vit_num,
    output logic [ADDR_W-1:0] in_addr,
    output logic [DATA_W-1:0] in_data,
    output logic              is_write,
    output logic              vit_cs_allow,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic              rsp_vit,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = 2 + ADDR_W + DATA_W;
    localparam int ACC_W   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCESS_CYCLES - 1);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            ACCESS_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("vit_cmd_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        ACCESS   = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t state_reg;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    logic               head_write;
    logic               head_vit;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;

    logic               cur_write_reg;
    logic [ACC_W-1:0]   acc_cnt_reg;
    logic               sel_code;

    // A full queue refuses a push even when the sequencer pops at the same edge.
    assign cmd_ready  = (count_reg != CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_pop   = (state_reg == IDLE) && !fifo_empty;

    assign {head_write, head_vit, head_addr, head_data} = fifo_mem[rd_ptr_reg];

    assign sel_code = vit_num ? vit2_code : vit1_code;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_write, cmd_vit, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef VIT_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt_reg;
    logic            rsp_err_reg;
    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            vit_num       <= 1'b0;
            in_addr       <= '0;
            in_data       <= '0;
            is_write      <= 1'b0;
            vit_cs_allow  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_vit       <= 1'b0;
            rsp_data      <= '0;
            cur_write_reg <= 1'b0;
            acc_cnt_reg   <= '0;
`ifdef VIT_SEQ_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        vit_num       <= head_vit;
                        in_addr       <= head_addr;
                        in_data       <= head_data;
                        cur_write_reg <= head_write;
`ifdef VIT_SEQ_TIMEOUT_EN
                        wait_cnt_reg  <= '0;
`endif
                        state_reg     <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    // A ready arriving on the limit edge still wins over the timeout.
                    if (sel_code) begin
                        vit_cs_allow <= 1'b1;
                        is_write     <= cur_write_reg;
                        acc_cnt_reg  <= '0;
                        state_reg    <= ACCESS;
                    end
`ifdef VIT_SEQ_TIMEOUT_EN
                    else if (wait_cnt_reg == TO_LAST) begin
                        rsp_valid   <= 1'b1;
                        rsp_write   <= cur_write_reg;
                        rsp_vit     <= vit_num;
                        rsp_data    <= '0;
                        rsp_err_reg <= 1'b1;
                        state_reg   <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                ACCESS: begin
                    // Ready code is deliberately ignored here; the window always completes.
                    if (acc_cnt_reg == ACC_LAST) begin
                        vit_cs_allow <= 1'b0;
                        is_write     <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= cur_write_reg;
                        rsp_vit      <= vit_num;
                        rsp_data     <= cur_write_reg ? '0 : vit_rd_data;
`ifdef VIT_SEQ_TIMEOUT_EN
                        rsp_err_reg  <= 1'b0;
`endif
                        state_reg    <= RESP;
                    end else begin
                        acc_cnt_reg <= acc_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
`ifdef VIT_SEQ_TIMEOUT_EN
                    rsp_err_reg <= 1'b0;
`endif
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vit_cmd_sequencer.sv
// Self-checking bench for vit_cmd_sequencer: transaction-level queue model plus
// directed literal checks; define VIT_SEQ_TIMEOUT_EN to exercise the timeout path.
module tb_vit_cmd_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int ACC    = 2;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic              cmd_vit;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              vit1_code;
    logic              vit2_code;
    logic [DATA_W-1:0] vit_rd_data;
    logic              vit_num;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              is_write;
    logic              vit_cs_allow;
    logic              rsp_valid;
    logic              rsp_write;
    logic              rsp_vit;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    always #5 clk = ~clk;

    vit_cmd_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH),
        .ACCESS_CYCLES(ACC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_vit(cmd_vit), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .vit1_code(vit1_code), .vit2_code(vit2_code), .vit_rd_data(vit_rd_data),
        .vit_num(vit_num), .in_addr(in_addr), .in_data(in_data),
        .is_write(is_write), .vit_cs_allow(vit_cs_allow),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_vit(rsp_vit),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    typedef struct packed {
        logic              w;
        logic              v;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } cmd_t;

    int total = 0;
    int bad   = 0;
    int rsp_cnt = 0;

    // Transaction model: a queue of pending commands plus the one in service.
    cmd_t mq[$];
    cmd_t m_cur;
    cmd_t inc;
    bit   m_busy = 1'b0;
    int   m_phase;      // 0 waiting for ready, 1 in access window, 2 responding
    int   m_left;
    int   m_waited;
    bit   can_push;

    logic              e_ready = 1'b1, e_cs = 1'b0, e_wr = 1'b0, e_num = 1'b0, e_rv = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_data = '0;
    logic              e_rw = 1'b0, e_rvit = 1'b0, e_rerr = 1'b0;
    logic [DATA_W-1:0] e_rdata = '0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_busy = 1'b0;
            e_cs = 0; e_wr = 0; e_num = 0; e_addr = '0; e_data = '0;
            e_rv = 0; e_rw = 0; e_rvit = 0; e_rdata = '0; e_rerr = 0;
        end else begin
            can_push = (mq.size() < DEPTH);
            inc = {cmd_write, cmd_vit, cmd_addr, cmd_wdata};
            if (!m_busy) begin
                if (mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    m_busy = 1'b1;
                    m_phase = 0;
                    m_waited = 0;
                    e_num = m_cur.v; e_addr = m_cur.a; e_data = m_cur.d;
                end
            end else if (m_phase == 0) begin
                if (m_cur.v ? vit2_code : vit1_code) begin
                    m_phase = 1;
                    m_left = ACC;
                    e_cs = 1'b1;
                    e_wr = m_cur.w;
                end
`ifdef VIT_SEQ_TIMEOUT_EN
                else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_phase = 2;
                        e_rv = 1; e_rw = m_cur.w; e_rvit = m_cur.v; e_rdata = '0; e_rerr = 1;
                    end
                end
`endif
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin
                    e_cs = 0; e_wr = 0;
                    e_rv = 1; e_rw = m_cur.w; e_rvit = m_cur.v; e_rerr = 0;
                    e_rdata = m_cur.w ? '0 : vit_rd_data;
                    m_phase = 2;
                end
            end else begin
                e_rv = 0; e_rerr = 0;
                m_busy = 1'b0;
            end
            if (cmd_valid && can_push) mq.push_back(inc);
        end
        e_ready = (mq.size() < DEPTH);
        #1;
        total++;
        if ({cmd_ready, vit_cs_allow, is_write, vit_num, in_addr, in_data, rsp_valid} !==
            {e_ready, e_cs, e_wr, e_num, e_addr, e_data, e_rv}) begin
            bad++;
            $display("FAIL cycle_bus t=%0t act rdy=%b cs=%b wr=%b num=%b addr=%h data=%h rv=%b req rdy=%b cs=%b wr=%b num=%b addr=%h data=%h rv=%b",
                     $time, cmd_ready, vit_cs_allow, is_write, vit_num, in_addr, in_data, rsp_valid,
                     e_ready, e_cs, e_wr, e_num, e_addr, e_data, e_rv);
        end
        if (e_rv) begin
            total++;
            if ({rsp_write, rsp_vit, rsp_data, rsp_err} !== {e_rw, e_rvit, e_rdata, e_rerr}) begin
                bad++;
                $display("FAIL cycle_rsp t=%0t act w=%b vit=%b data=%h err=%b req w=%b vit=%b data=%h err=%b",
                         $time, rsp_write, rsp_vit, rsp_data, rsp_err, e_rw, e_rvit, e_rdata, e_rerr);
            end
        end
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            $display("rsp %0d t=%0t w=%b vit=%b data=%h err=%b", rsp_cnt, $time,
                     rsp_write, rsp_vit, rsp_data, rsp_err);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic drive_cmd(input logic w, input logic v, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        cmd_write = w; cmd_vit = v; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    endtask

    task automatic wait_rsps(input int n, input int budget, input string name);
        int start;
        int cyc;
        start = rsp_cnt;
        cyc = 0;
        while (rsp_cnt - start < n && cyc < budget) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk(name, rsp_cnt - start, n);
    endtask

    int idx;
    int n;

    initial begin
        reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_vit = 0; cmd_addr = '0;
        cmd_wdata = '0; vit1_code = 0; vit2_code = 0; vit_rd_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_outs", {vit_num, in_addr, in_data, is_write, vit_cs_allow, rsp_valid,
                         rsp_write, rsp_vit, rsp_data, rsp_err}, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #2;
        chk("idle_no_rsp", rsp_valid, 0);

        // Write to vit1 with target already ready
        @(negedge clk); vit1_code = 1; drive_cmd(1, 0, 3'b010, 8'hAB);
        @(posedge clk);
        @(negedge clk); cmd_valid = 0;
        @(posedge clk); @(posedge clk); #2;
        chk("wr_bus_e2", {vit_cs_allow, is_write, vit_num, in_addr, in_data}, {1'b1, 1'b1, 1'b0, 3'b010, 8'hAB});
        @(posedge clk); #2;
        chk("wr_cs_e3", {vit_cs_allow, rsp_valid}, 2'b10);
        @(posedge clk); #2;
        chk("wr_rsp_e4", {vit_cs_allow, is_write, rsp_valid, rsp_write, rsp_vit, rsp_data}, {3'b001, 2'b10, 8'h00});
        @(posedge clk); #2;
        chk("wr_rsp_gone", rsp_valid, 0);

        // Read from vit2, target ready after 6 cycles
        @(negedge clk); vit1_code = 0; vit2_code = 0; vit_rd_data = 8'h5C; drive_cmd(0, 1, 3'b101, 8'h00);
        @(posedge clk);
        @(negedge clk); cmd_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            chk("rd_wait_cs", vit_cs_allow, 0);
        end
        @(negedge clk); vit2_code = 1;
        @(posedge clk); #2;
        chk("rd_access", {vit_cs_allow, is_write, vit_num, in_addr}, {3'b101, 3'b101});
        @(posedge clk); @(posedge clk); #2;
        chk("rd_rsp", {rsp_valid, rsp_write, rsp_vit, rsp_data}, {3'b101, 8'h5C});

        // Queue fill with both codes low
        @(negedge clk); vit1_code = 0; vit2_code = 0;
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            vit_rd_data = 8'h30 + 8'(c);
            if (idx < 6) drive_cmd(1'(idx), 1'(idx >> 1), 3'(idx + 1), 8'h10 + 8'(idx));
            else cmd_valid = 0;
            if (cmd_ready) idx++;
            @(posedge clk);
        end
        @(negedge clk); cmd_valid = 0;
        chk("fill_accepted", idx, 5);
        chk("fill_ready_low", cmd_ready, 0);
        vit1_code = 1; vit2_code = 1;
        wait_rsps(5, 60, "fill_rsps");
        chk("fill_ready_back", cmd_ready, 1);

        // Reset during the first access cycle with two commands queued
        @(negedge clk); vit1_code = 0; vit2_code = 0;
        idx = 0;
        n = 0;
        while (idx < 3 && n < 20) begin
            drive_cmd(1, 0, 3'(idx), 8'hC0 + 8'(idx));
            if (cmd_ready) idx++;
            @(posedge clk); @(negedge clk);
            n++;
        end
        cmd_valid = 0;
        chk("rst5_queued", idx, 3);
        vit1_code = 1;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (vit_cs_allow !== 1'b1 && n < 20);
        chk("rst5_reached_access", vit_cs_allow, 1);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("rst5_cs_drop", {vit_cs_allow, is_write, cmd_ready, rsp_valid}, 4'b0010);
        @(negedge clk); reset = 1'b0;
        n = rsp_cnt;
        repeat (20) @(posedge clk);
        #2;
        chk("rst5_no_rsp", rsp_cnt - n, 0);

`ifdef VIT_SEQ_TIMEOUT_EN
        // Timeout on vit1 read, then a vit2 write proceeds
        @(negedge clk); vit1_code = 0; vit2_code = 0; drive_cmd(0, 0, 3'b011, 8'h00);
        @(posedge clk);
        @(negedge clk); drive_cmd(1, 1, 3'b100, 8'h77);
        @(posedge clk);
        @(negedge clk); cmd_valid = 0;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
            chk("to_cs_low", vit_cs_allow, 0);
        end while (rsp_valid !== 1'b1 && n < 30);
        chk("to_wait_cycles", n, 8);
        chk("to_rsp", {rsp_valid, rsp_err, rsp_write, rsp_vit, rsp_data}, {4'b1100, 8'h00});
        @(negedge clk); vit2_code = 1;
        wait_rsps(1, 30, "to_next_rsp");
        chk("to_next_fields", {rsp_err, rsp_write, rsp_vit}, 3'b011);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_write = 1'($urandom);
            cmd_vit = 1'($urandom);
            cmd_addr = 3'($urandom);
            cmd_wdata = 8'($urandom);
            vit1_code = ($urandom_range(0, 4) > 1);
            vit2_code = ($urandom_range(0, 4) > 1);
            vit_rd_data = 8'($urandom);
        end
        @(negedge clk);
        reset = 0; cmd_valid = 0; vit1_code = 1; vit2_code = 1;
        n = 0;
        while ((mq.size() > 0 || m_busy) && n < 200) begin
            @(posedge clk); #2; n++;
        end
        chk("drain_done", {31'd0, (mq.size() > 0 || m_busy)}, 0);
        @(posedge clk); #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vit_cmd_sequencer.md
Name: vit_cmd_sequencer

Overview:
Upstream command stage for the Viterbi chip-select/bus snipet. It queues host read/write commands aimed at Viterbi unit 1 or 2, waits for the target's ready code, then drives vit_num, in_addr, in_data, is_write and vit_cs_allow to the snipet for a fixed access window. It returns a single-cycle response per command, carrying captured read data for reads.

Parameters:
DATA_W, 8, data bus width
ADDR_W, 3, register address width
FIFO_DEPTH, 4, command queue entries (power of 2, >=2)
ACCESS_CYCLES, 2, cycles vit_cs_allow is held per access (>=1)
TIMEOUT_CYCLES, 8, WAIT_RDY cycle limit (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  host command present
cmd_ready  out  1  queue can accept
cmd_write  in  1  1=write, 0=read
cmd_vit  in  1  target: 0=vit1, 1=vit2
cmd_addr  in  ADDR_W  register address
cmd_wdata  in  DATA_W  write data
vit1_code  in  1  vit1 ready code
vit2_code  in  1  vit2 ready code
vit_rd_data  in  DATA_W  read data returned from snipet bus
vit_num  out  1  target select to snipet
in_addr  out  ADDR_W  address to snipet
in_data  out  DATA_W  write data to snipet
is_write  out  1  write strobe to snipet
vit_cs_allow  out  1  chip-select enable to snipet
rsp_valid  out  1  one-cycle response pulse
rsp_write  out  1  completed command was a write
rsp_vit  out  1  completed command target
rsp_data  out  DATA_W  read data (0 for writes)
rsp_err  out  1  command timed out

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset; sampled on rising clk only.
- Reset: FIFO emptied, state IDLE, every output 0 except cmd_ready=1. Reset mid-operation discards queued and in-flight commands with no response. vit_cs_allow and is_write drop in the cycle after the reset edge.
- Push: cmd_valid && cmd_ready at an edge. cmd_ready = !fifo_full (combinational on count). At full, push refused even if a pop occurs at the same edge. Push and pop at the same edge on a non-full FIFO are both honoured.
- FIFO pointers wrap modulo FIFO_DEPTH. Commands complete strictly in order.
- FSM, all outputs registered:
  - IDLE: if FIFO non-empty, pop the head into the command register, load vit_num/in_addr/in_data, go to WAIT_RDY.
  - WAIT_RDY: sel_code = vit_num ? vit2_code : vit1_code. If sel_code==1, go to ACCESS, set vit_cs_allow=1, is_write=cmd_write, clear access counter.
  - ACCESS: hold all bus outputs stable. Counter increments each cycle. At the edge where counter==ACCESS_CYCLES-1: capture vit_rd_data (reads only), clear vit_cs_allow and is_write, set rsp_* and rsp_valid=1, go to RESP. The ready code is ignored during ACCESS; a drop does not abort.
  - RESP: rsp_valid=1 for exactly this one cycle, then go to IDLE. No backpressure.
- is_write is 1 only while vit_cs_allow=1 and the command is a write. vit_num/in_addr/in_data hold their last value in IDLE.
- Latency with empty FIFO and target ready: accept at edge 0 -> vit_cs_allow high after edge 2 -> rsp_valid high after edge ACCESS_CYCLES+2.
- Back-to-back throughput: one command per ACCESS_CYCLES+3 cycles.
- rsp_data = 0 for writes and errors.

Optional Feature:
VIT_SEQ_TIMEOUT_EN
- Defined: WAIT_RDY counts cycles. If sel_code is still 0 after TIMEOUT_CYCLES cycles, go to RESP with rsp_err=1, rsp_data=0. No access occurs and vit_cs_allow stays 0. A ready arriving on the same edge the limit is reached wins, and the access proceeds.
- Undefined: WAIT_RDY waits indefinitely. rsp_err is tied 0. The port remains present.

Test Plan:
1. Assert reset 3 cycles -> all outputs 0, cmd_ready=1. Release -> state IDLE, no rsp_valid.
2. Write vit1, addr 3'b010, data 8'hAB, vit1_code=1 -> vit_num=0, in_addr=010, in_data=AB, is_write=vit_cs_allow=1 for exactly 2 cycles starting after edge 2. rsp_valid pulse after edge 4 with rsp_write=1, rsp_vit=0.
3. Read vit2, addr 3'b101, vit2_code=0 for 6 cycles then 1, vit_rd_data=8'h5C -> vit_cs_allow only after code rises, is_write stays 0. Response has rsp_data=8'h5C, rsp_vit=1.
4. Both codes 0, cmd_valid held with 6 distinct commands -> 5 accepted (4 queued + 1 in flight), cmd_ready=0. Raise codes -> 5 in-order responses, cmd_ready returns 1 after the first pop.
5. Assert reset during the 1st ACCESS cycle of a write with 2 commands queued -> vit_cs_allow=0 next cycle, no rsp_valid ever, cmd_ready=1.
6. With VIT_SEQ_TIMEOUT_EN, codes held 0 -> rsp_valid with rsp_err=1 after 8 WAIT_RDY cycles, vit_cs_allow never 1. The next queued command proceeds normally.
